// File: rtl/bch_encode_stream_if.sv
// Valid/ready handshake bundle for the streaming BCH encoder: input data channel
// plus the tagged output word channel.
interface bch_encode_stream_if #(
   parameter int BITS  = 1,
   parameter int LEN_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [BITS-1:0]  in_data;
   logic [LEN_W-1:0] in_len;
   logic             out_valid;
   logic             out_ready;
   logic [BITS-1:0]  out_data;
   logic             out_first;
   logic             out_last;
   logic             out_ecc;

   modport master (
      output in_valid, in_data, in_len, out_ready,
      input  in_ready, out_valid, out_data, out_first, out_last, out_ecc
   );

   modport slave (
      input  in_valid, in_data, in_len, out_ready,
      output in_ready, out_valid, out_data, out_first, out_last, out_ecc
   );
endinterface

// File: rtl/bch_encode_stream.sv
// Streaming systematic BCH encoder: passes data words through, then appends the
// ECC words of each variable-length (shortened) codeword with no idle cycles.
module bch_encode_stream #(
   parameter int                  DATA_BITS = 7,
   parameter int                  ECC_BITS  = 8,
   parameter logic [ECC_BITS-1:0] ENC       = 8'hD1,
   parameter int                  BITS      = 1,
   parameter int                  LEN_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   bch_encode_stream_if.slave bus
);
   localparam int DATA_WORDS_MAX = DATA_BITS / BITS;
   localparam int ECC_WORDS      = (ECC_BITS + BITS - 1) / BITS;
   localparam int CNT_W          = (ECC_WORDS > 1) ? $clog2(ECC_WORDS) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_WORDS_MAX);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ECC_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, DATA, ECC} state_t;

   state_t              state_q;
   logic [ECC_BITS-1:0] lfsr_q;
   logic [LEN_W-1:0]    remaining_q;
   logic [CNT_W-1:0]    ecc_cnt_q;
   logic                out_valid_q;
   logic                out_first_q;
   logic                out_last_q;
   logic                out_ecc_q;
   logic [BITS-1:0]     out_data_q;

   logic                advance;
   logic                take;
   logic [LEN_W-1:0]    len_clamped;
   logic [BITS-1:0]     ecc_word;
   logic [ECC_BITS-1:0] lfsr_d;
   logic [ECC_BITS-1:0] chain [BITS+1];

   assign advance     = !out_valid_q || bus.out_ready;
   assign bus.in_ready = advance && (state_q != ECC);
   assign take        = bus.in_valid && bus.in_ready;
   assign len_clamped = (bus.in_len == '0 || bus.in_len > LEN_MAX) ? LEN_MAX : bus.in_len;

   // The first word of a codeword divides from a zero remainder.
   assign chain[0] = (state_q == IDLE) ? '0 : lfsr_q;

   for (genvar gi = 0; gi < BITS; gi++) begin : g_step
      logic fb;
      assign fb = chain[gi][ECC_BITS-1] ^ bus.in_data[BITS-1-gi];
      assign chain[gi+1] = {chain[gi][ECC_BITS-2:0], 1'b0} ^ (fb ? ENC : '0);
   end

   assign lfsr_d = chain[BITS];

   // The remainder is shifted out MSB first; the last word is zero-padded when narrow.
   if (ECC_BITS >= BITS) begin : g_ecc_wide
      assign ecc_word = lfsr_q[ECC_BITS-1 -: BITS];
   end else begin : g_ecc_narrow
      assign ecc_word = {lfsr_q, {(BITS-ECC_BITS){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lfsr_q      <= '0;
         remaining_q <= '0;
         ecc_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ecc_q   <= 1'b0;
         out_data_q  <= '0;
      end else if (advance) begin
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ecc_q   <= 1'b0;
         case (state_q)
            IDLE: if (take) begin
               out_valid_q <= 1'b1;
               out_first_q <= 1'b1;
               out_data_q  <= bus.in_data;
               lfsr_q      <= lfsr_d;
               remaining_q <= len_clamped - LEN_ONE;
               state_q     <= (len_clamped == LEN_ONE) ? ECC : DATA;
            end
            DATA: if (take) begin
               out_valid_q <= 1'b1;
               out_data_q  <= bus.in_data;
               lfsr_q      <= lfsr_d;
               remaining_q <= remaining_q - LEN_ONE;
               if (remaining_q == LEN_ONE) state_q <= ECC;
            end
            ECC: begin
               out_valid_q <= 1'b1;
               out_ecc_q   <= 1'b1;
               out_data_q  <= ecc_word;
               lfsr_q      <= lfsr_q << BITS;
               if (ecc_cnt_q == CNT_LAST) begin
                  out_last_q <= 1'b1;
                  ecc_cnt_q  <= '0;
                  state_q    <= IDLE;
               end else begin
                  ecc_cnt_q <= ecc_cnt_q + CNT_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_first = out_first_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_ecc   = out_ecc_q;
endmodule

// File: tb/tb_bch_encode_stream.sv
// Directed and randomised-backpressure bench for the (15,7) BCH stream encoder,
// using 1-bit and 4-bit datapath instances.
module tb_bch_encode_stream;
   localparam int EB = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bch_encode_stream_if #(.BITS(1), .LEN_W(16)) s1 ();
   bch_encode_stream_if #(.BITS(4), .LEN_W(16)) s4 ();

   bch_encode_stream #(.DATA_BITS(7), .ECC_BITS(8), .ENC(8'hD1), .BITS(1), .LEN_W(16)) dut1 (
      .clk(clk), .reset(reset), .bus(s1.slave));
   bch_encode_stream #(.DATA_BITS(7), .ECC_BITS(8), .ENC(8'hD1), .BITS(4), .LEN_W(16)) dut4 (
      .clk(clk), .reset(reset), .bus(s4.slave));

   int n_vec  = 0;
   int n_miss = 0;

   // Words are kept as {data[3:0], first, last, ecc}.
   logic [6:0] q_exp1[$];
   logic [6:0] q_got1[$];
   logic [6:0] q_got4[$];

   bit   rand_rdy  = 1'b0;
   bit   chk_gap   = 1'b0;
   int   cyc       = 0;
   int   last_cyc  = -1;
   int   gaps_seen = 0;
   int   gap_err   = 0;
   int   stall_err = 0;
   int   n_stall   = 0;
   logic prev_stall = 1'b0;
   logic [6:0] held = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Remainder of msg(x)*x^8 divided by g(x) = 0x1D1, by long division.
   function automatic logic [7:0] ref_ecc(input logic [6:0] msg);
      logic [14:0] r;
      r = {msg, 8'h00};
      for (int b = 14; b >= 8; b--)
         if (r[b]) r = r ^ (15'h1D1 << (b - 8));
      return r[7:0];
   endfunction

   always @(posedge clk) begin
      #1;
      s1.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && {3'b000, s1.out_data, s1.out_first, s1.out_last, s1.out_ecc} != held)
            stall_err++;
         if (s1.out_valid && s1.out_ready) begin
            q_got1.push_back({3'b000, s1.out_data, s1.out_first, s1.out_last, s1.out_ecc});
            if (s1.out_first && chk_gap && last_cyc >= 0) begin
               gaps_seen++;
               if (cyc != last_cyc + 1) gap_err++;
            end
            if (s1.out_last) last_cyc = cyc;
         end
         prev_stall = s1.out_valid && !s1.out_ready;
         if (prev_stall) n_stall++;
         held = {3'b000, s1.out_data, s1.out_first, s1.out_last, s1.out_ecc};
      end
   end

   always @(negedge clk) begin
      if (!reset && s4.out_valid && s4.out_ready)
         q_got4.push_back({s4.out_data, s4.out_first, s4.out_last, s4.out_ecc});
   end

   // Drives n message bits (MSB first) as one codeword; optionally queues the expected words.
   task automatic send1(input int len_field, input int n, input logic [6:0] msg,
                        input logic [7:0] ecc, input bit push, output int first_wait);
      int w;
      first_wait = 0;
      if (push) begin
         for (int i = 0; i < n; i++)
            q_exp1.push_back({3'b000, msg[n-1-i], (i == 0), 1'b0, 1'b0});
         for (int i = 0; i < EB; i++)
            q_exp1.push_back({3'b000, ecc[EB-1-i], 1'b0, (i == EB - 1), 1'b1});
      end
      $display("codeword len_field=%0d words=%0d msg=%b ecc=%h", len_field, n, msg, ecc);
      for (int i = 0; i < n; i++) begin
         s1.in_valid = 1'b1;
         s1.in_data  = msg[n-1-i];
         s1.in_len   = len_field[15:0];
         w = 0;
         @(negedge clk);
         while (!s1.in_ready && w < 200) begin
            w++;
            @(negedge clk);
         end
         if (w >= 200) check("in_ready_timeout", w, 0);
         if (i == 0) first_wait = w;
         @(posedge clk);
         #1;
      end
      s1.in_valid = 1'b0;
   endtask

   task automatic compare1(input string tag);
      int w = 0;
      while (q_got1.size() < q_exp1.size() && w < 3000) begin
         @(negedge clk);
         w++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_count"}, q_got1.size(), q_exp1.size());
      for (int i = 0; i < q_exp1.size() && i < q_got1.size(); i++)
         check($sformatf("%s[%0d]", tag, i), q_got1[i], q_exp1[i]);
      $display("%s: %0d expected words compared", tag, q_exp1.size());
      q_exp1.delete();
      q_got1.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fw;
      int w;
      int n;
      logic [6:0] msg;
      logic [6:0] exp4 [6];

      s1.in_valid = 1'b0; s1.in_data = '0; s1.in_len = '0;
      s4.in_valid = 1'b0; s4.in_data = '0; s4.in_len = '0; s4.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", s1.out_valid, 0);
      check("rst_in_ready", s1.in_ready, 1);
      check("rst_out_fields", {s1.out_first, s1.out_last, s1.out_ecc, s1.out_data}, 0);
      @(posedge clk);
      #1;

      // Back-to-back directed codewords with continuous flow.
      chk_gap = 1'b1;
      send1(7, 7, 7'b1111111, 8'hFF, 1'b1, fw);
      check("cw_ones_first_wait", fw, 0);
      send1(7, 7, 7'b0000000, 8'h00, 1'b1, fw);
      check("cw_zeros_in_ready_low", fw, 8);
      send1(7, 7, 7'b1000000, 8'hE8, 1'b1, fw);
      check("cw_x6_in_ready_low", fw, 8);
      compare1("directed");
      chk_gap = 1'b0;
      check("gaps_seen", gaps_seen, 2);
      check("gap_cycles", gap_err, 0);

      // Length clamping, short codeword and single-word codeword.
      send1(0, 7, 7'b1000000, 8'hE8, 1'b1, fw);
      send1(100, 7, 7'b1111111, 8'hFF, 1'b1, fw);
      send1(3, 3, 7'b0000111, 8'h44, 1'b1, fw);
      send1(1, 1, 7'b0000001, 8'hD1, 1'b1, fw);
      compare1("clamp_short");

      // Reset in the middle of the data phase.
      send1(7, 4, 7'b1011011, 8'h00, 1'b0, fw);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_data_out_valid", s1.out_valid, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_data_in_ready", s1.in_ready, 1);
      q_got1.delete();
      repeat (5) @(negedge clk);
      check("rst_data_no_emit", q_got1.size(), 0);
      @(posedge clk);
      #1;
      send1(7, 7, 7'b1000000, 8'hE8, 1'b1, fw);
      compare1("after_rst_data");

      // Reset in the middle of the ECC phase.
      send1(7, 7, 7'b1111111, 8'h00, 1'b0, fw);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ecc_out_valid", s1.out_valid, 0);
      check("rst_ecc_out_ecc", s1.out_ecc, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ecc_in_ready", s1.in_ready, 1);
      q_got1.delete();
      repeat (5) @(negedge clk);
      check("rst_ecc_no_emit", q_got1.size(), 0);
      @(posedge clk);
      #1;
      send1(3, 3, 7'b0000111, 8'h44, 1'b1, fw);
      compare1("after_rst_ecc");

      // Random lengths and data under random backpressure.
      rand_rdy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         n   = $urandom_range(1, 7);
         msg = 7'($urandom_range(0, (1 << n) - 1));
         send1(n, n, msg, ref_ecc(msg), 1'b1, fw);
      end
      compare1("random");
      rand_rdy = 1'b0;
      check("stalls_seen", (n_stall > 0), 1);
      check("stall_hold", stall_err, 0);

      // 4-bit datapath: one data word per codeword, two ECC words.
      exp4[0] = 7'b0111_100; exp4[1] = 7'b0100_001; exp4[2] = 7'b0100_011;
      exp4[3] = 7'b1000_100; exp4[4] = 7'b0001_001; exp4[5] = 7'b1101_011;
      s4.in_valid = 1'b1; s4.in_data = 4'b0111; s4.in_len = 16'd1;
      $display("codeword4 len_field=1 data=0111");
      w = 0;
      @(negedge clk);
      while (!s4.in_ready && w < 50) begin w++; @(negedge clk); end
      check("b4_first_wait", w, 0);
      @(posedge clk);
      #1;
      s4.in_data = 4'b1000; s4.in_len = 16'd0;
      $display("codeword4 len_field=0 data=1000");
      w = 0;
      @(negedge clk);
      while (!s4.in_ready && w < 50) begin w++; @(negedge clk); end
      check("b4_in_ready_low", w, 2);
      @(posedge clk);
      #1;
      s4.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("b4_count", q_got4.size(), 6);
      for (int i = 0; i < 6 && i < q_got4.size(); i++)
         check($sformatf("b4[%0d]", i), q_got4[i], exp4[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/bch_encode_stream.md
Name: bch_encode_stream

Overview:
Streaming, parametrised BCH systematic encoder for continuous traffic. It accepts data words on a valid/ready input channel and emits each data word unchanged. After the last data word of a codeword, it emits the ECC words. Codeword length is selectable per codeword (shortened codes), and codewords run back to back with no idle cycle. It replaces the start/ce-driven encoder in datapaths that need backpressure and variable-length frames.

Parameters:
P, `BCH_SANE, packed BCH parameter set (M, T, data bits, ECC bits via `BCH_* macros)
BITS, 1, datapath width in bits per word; 1 <= BITS <= `BCH_DATA_BITS(P)
LEN_W, 16, width of in_len; must hold DATA_WORDS_MAX = `BCH_DATA_BITS(P)/BITS (integer division)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  input word present
in_ready  output  1  encoder accepts input word this cycle
in_data  input  BITS  data word; bit BITS-1 is the first (highest-order) message bit
in_len  input  LEN_W  data words in this codeword; sampled only on the first accepted word of a codeword
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts output word
out_data  output  BITS  data word or ECC word
out_first  output  1  word is the first data word of a codeword
out_last  output  1  word is the final ECC word of a codeword
out_ecc  output  1  word is ECC (0 = data)

Behaviour:
- Derived constants:
  - ECC_WORDS = ceil(`BCH_ECC_BITS(P)/BITS).
  - ENC = encoder_poly(0), the generator polynomial without its top term.
- Shortening: encoding N < DATA_WORDS_MAX words equals encoding the full code with leading zero words. No padding words are emitted.
- in_len handling: 0 or > DATA_WORDS_MAX is clamped to DATA_WORDS_MAX.
- Output stage: one register. advance = !out_valid || out_ready.
- Handshakes:
  - in_ready = advance && state != ECC.
  - An input word transfers when in_valid && in_ready.
  - An output word transfers when out_valid && out_ready.
  - out_data/out_first/out_last/out_ecc are held stable while out_valid && !out_ready.
- FSM states: IDLE, DATA, ECC.
  - IDLE, on transfer: load the word into the output register with out_first=1.
    - lfsr <= step(0, in_data).
    - remaining <= clamped in_len - 1.
    - Go to ECC if clamped len == 1, else DATA.
  - DATA, on transfer: load the word into the output register.
    - lfsr <= step(lfsr, in_data).
    - Decrement remaining; go to ECC when the word taken had remaining == 1.
  - ECC, on advance: load out_data = top BITS of lfsr, left-aligned, low bits zero-padded on the final word.
    - Set out_ecc=1 and lfsr <= lfsr << BITS.
    - Increment ecc_cnt; on word ECC_WORDS set out_last=1, clear ecc_cnt and go to IDLE.
- step(s, w): for i = BITS-1 downto 0: fb = s[msb]^w[i]; s = (s<<1) ^ (fb ? ENC : 0).
- Latency: the input word appears on out_* the cycle after transfer. The first ECC word appears the cycle after the last data word is loaded, when advance holds.
- Back-to-back: IDLE is entered as the final ECC word loads. A new codeword's first word can load on the next advance, so there is no bubble between out_last and the next out_first.
- When advance && no load: out_valid <= 0.
- Reset (sync, any state, mid-codeword included):
  - state=IDLE, lfsr=0, remaining=0, ecc_cnt=0.
  - out_valid=0, out_first=0, out_last=0, out_ecc=0, out_data=0.
  - in_ready is 1 the cycle after reset deasserts.
  - A partial codeword is discarded; nothing further is emitted for it.
- Single-word ECC (ECC_WORDS == 1) and single-word data (len 1) must both work, including together.

Test Plan:
- M=4,T=2 (n=15,k=7), BITS=1, out_ready=1, len 7, data 1111111 -> out_data 1111111 then ECC 11111111; out_last on 15th word; in_ready low exactly 8 cycles.
- Same P, data 0000000 -> ECC 00000000. Data 1000000 -> ECC matches a bit-serial software divide by g(x)=0x1D1.
- Same P, BITS=4, len 1, data 4'b0111 -> one data word, ECC words 2 (8 bits, no pad). ECC equals the full-code result for data 0000111.
- Random out_ready at 50%, 20 back-to-back codewords of random len 1..7 -> every codeword matches the model. No word is lost or duplicated and out_* are held stable during stalls. There is no gap between out_last and the next out_first when in_valid and out_ready are continuous.
- in_len=0 and in_len=100 -> treated as 7 words; the following codeword is correct.
- reset asserted mid-DATA and mid-ECC -> next cycle out_valid=0, state IDLE. The next codeword encodes correctly from lfsr=0.
